// File: rtl/sample_packer_pkg.sv
// Shared types and helpers for the sample packer and its drop counter.
package sample_packer_pkg;

  typedef enum logic {FILL, HOLD} state_t;

  function automatic int unsigned idx_w(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Increment v, clamping at the largest value representable in w bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Narrow sample input and wide packed-word valid/ready output of the sample packer.
interface sample_packer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RATIO = 8
);
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic [WIDTH*RATIO-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/sample_packer_sat_counter.sv
// Saturating event counter with synchronous clear; an increment in the clear cycle leaves 1.
module sat_counter
  import sample_packer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_WIDTH'(1) : '0;
    end else if (inc) begin
      cnt <= CNT_WIDTH'(sat_inc(64'(cnt), CNT_WIDTH));
    end
  end

endmodule

// File: rtl/sample_packer.sv
// Packs RATIO narrow samples LSB-first into one wide word behind a valid/ready register;
// words completing while the register is full and not draining are dropped and counted.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RATIO     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  sample_packer_if.master      bus,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  input  logic                 clr_overflow
);

  localparam int unsigned       IDX_W  = idx_w(RATIO);
  localparam int unsigned       WORD_W = WIDTH * RATIO;
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(RATIO - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] out_data_q;
  logic              accept;
  logic              complete;
  logic              load;
  logic              drop;

  // The completing sample bypasses the accumulator straight into the top slot.
  always_comb begin
    accept   = bus.in_valid && enable;
    complete = accept && (idx == LAST);
    load     = complete && ((state == FILL) || bus.out_ready);
    drop     = complete && !load;
    word     = acc;
    word[WORD_W-WIDTH +: WIDTH] = bus.in_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (load) state_nxt = HOLD;
      HOLD:    if (bus.out_ready && !load) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || !enable) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      acc[idx*WIDTH +: WIDTH] <= bus.in_data;
      idx <= complete ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_data_q <= '0;
    end else if (load) begin
      out_data_q <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (drop),
    .clr    (clr_overflow),
    .cnt    (drop_cnt)
  );

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state == HOLD);

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Sits in the read-clock domain directly downstream of data_resync. Consumes its narrow resynchronised sample stream and packs RATIO consecutive samples into one wide word.
- Presents each word on a valid/ready interface to the capture/DMA side.
- Flags words lost to backpressure with a sticky overflow bit and a saturating drop counter.

Parameters:
- WIDTH, 4, bits per input sample (equals data_resync WIDTH).
- RATIO, 8, samples per output word; legal range 2..64.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  single clock (the read clock of data_resync).
- resetn  in  1  synchronous active-low reset.
- enable  in  1  packing enable; low flushes any partial word.
- in_data  in  WIDTH  sample from data_resync rd_data.
- in_valid  in  1  sample strobe; a sample is accepted when in_valid & enable.
- out_data  out  WIDTH*RATIO  packed word; sample k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- overflow  out  1  sticky: at least one completed word was dropped.
- drop_cnt  out  CNT_WIDTH  number of dropped words, saturating.
- clr_overflow  in  1  clears overflow and drop_cnt.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - out_data=0, out_valid=0, overflow=0, drop_cnt=0.
  - Slot index idx=0 and the accumulator are cleared.
  - Reset overrides all other inputs, including mid-word and with out_valid high; a pending word is lost and not counted.
- Fill:
  - Each accepted sample is written to accumulator slot idx.
  - If idx<RATIO-1, idx increments.
  - Slots are filled LSB-first: the first sample goes to bits [WIDTH-1:0].
- Completion:
  - The sample accepted with idx=RATIO-1 completes the word, and idx wraps to 0 in the same cycle.
  - The completed word (accumulator plus the current sample) is offered to the output register.
- Output register:
  - Loads when out_valid=0 or (out_valid & out_ready) in the completion cycle.
  - If it loads: out_data=new word and out_valid=1 on the next clock. Latency is one clk from the final sample edge to out_valid.
  - If it cannot load, the word is dropped: out_data holds, overflow<=1, drop_cnt<=drop_cnt+1, saturating at 2^CNT_WIDTH-1.
- Handshake:
  - A transfer occurs on a cycle with out_valid & out_ready.
  - Without a simultaneous completion, out_valid<=0 after a transfer.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- Gaps: in_valid may be low on any cycle; idx and the accumulator hold.
- enable=0:
  - idx<=0 and the partial word is discarded, not counted as a drop.
  - in_valid is ignored.
  - The output register and handshake continue normally, so a pending word can still drain.
- clr_overflow:
  - Clears overflow and drop_cnt on the next clock.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- Control: one two-state FSM, FILL/HOLD, reflecting out_valid. Packing progress is tracked by idx (counter 0..RATIO-1, width $clog2(RATIO)).
- The block adds no CDC logic. All inputs are synchronous to clk.

Decomposition:
- Package sample_packer_pkg:
  - IDX_W function/localparam ($clog2(RATIO)).
  - FSM state enum {FILL, HOLD}.
  - Saturating-increment function for drop_cnt.
- One sub-module: sat_counter (CNT_WIDTH, inc, clr, synchronous active-low reset). It is reusable elsewhere in the sync tree.

Test Plan:
- WIDTH=4, RATIO=8, out_ready=1, enable=1, feed 0..7 back-to-back -> out_data=32'h76543210, out_valid high exactly one cycle after sample 7, overflow=0.
- Same setup, in_valid toggled every other cycle with samples 8..15 -> out_data=32'hFEDCBA98 one cycle after the 8th accepted sample; idle cycles do not advance idx.
- out_ready=0, feed 16 samples 0..15 -> out_data stays 32'h76543210, second word dropped, overflow=1, drop_cnt=1. Then out_ready=1 for one cycle -> out_valid falls. Then pulse clr_overflow -> overflow=0, drop_cnt=0.
- Feed 0..4, drop enable for one cycle, re-enable and feed 0..7 -> single word 32'h76543210, drop_cnt=0. Repeat with resetn pulsed low after 5 samples -> same result, all outputs 0 during reset.
- CNT_WIDTH=4, out_ready=0, 20 completed words after the first -> drop_cnt saturates at 15, overflow=1. clr_overflow asserted in a drop cycle -> drop_cnt=1.
- out_valid=1, out_ready=1 in the same cycle a new word completes -> new word loaded with no bubble, out_valid stays 1, no drop counted.
